// File: rtl/mem_arbiter_pkg.sv
// Shared CPU definitions: arbiter FSM encoding and default fairness limit.
package mem_arbiter_pkg;
  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    GNT_I      = 2'd1,
    GNT_D      = 2'd2,
    GNT_I_KILL = 2'd3
  } arb_state_e;

  localparam int STARVE_LIMIT_DEF = 4;
  localparam int STARVE_W         = 3;
endpackage

// File: rtl/mem_arbiter_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         inc_i,
  input  logic         clr_i,
  output logic [W-1:0] cnt_o
);
  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)                       cnt_d = '0;
    else if (inc_i && cnt_q != '1)   cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;

  assign cnt_o = cnt_q;
endmodule

// File: rtl/mem_arbiter.sv
// Two-port (fetch/data) single-memory arbiter: data priority with fetch
// starvation guard, fetch cancellation on flush, per-port wait counters.
module mem_arbiter import mem_arbiter_pkg::*; #(
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEF,
  parameter int LAT_W        = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             if_req_i,
  input  logic [31:0]      if_addr_i,
  output logic [31:0]      if_rdata_o,
  output logic             if_ack_o,
  input  logic             flush_i,
  input  logic             d_req_i,
  input  logic             d_we_i,
  input  logic [31:0]      d_addr_i,
  input  logic [31:0]      d_wdata_i,
  output logic [31:0]      d_rdata_o,
  output logic             d_ack_o,
  output logic             mem_req_o,
  output logic             mem_we_o,
  output logic [31:0]      mem_addr_o,
  output logic [31:0]      mem_wdata_o,
  input  logic [31:0]      mem_rdata_i,
  input  logic             mem_ack_i,
  output logic             stall_o,
  output logic [LAT_W-1:0] if_wait_cnt_o,
  output logic [LAT_W-1:0] d_wait_cnt_o
);
  arb_state_e          state_q, state_d;
  logic [STARVE_W-1:0] starve_q, starve_d;
  logic [31:0]         addr_q, addr_d, wdata_q, wdata_d;
  logic                we_q, we_d;
  logic                starve_hit;

  assign starve_hit = (int'(starve_q) >= STARVE_LIMIT);

  always_comb begin
    state_d  = state_q;
    starve_d = starve_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    we_d     = we_q;
    unique case (state_q)
      IDLE: begin
        // A flushed fetch is never granted; data may still win that cycle.
        if (if_req_i && !flush_i && (!d_req_i || starve_hit)) begin
          state_d  = GNT_I;
          starve_d = '0;
          addr_d   = if_addr_i;
          wdata_d  = '0;
          we_d     = 1'b0;
        end else if (d_req_i) begin
          state_d = GNT_D;
          addr_d  = d_addr_i;
          wdata_d = d_wdata_i;
          we_d    = d_we_i;
          if (if_req_i && starve_q != '1) starve_d = starve_q + 1'b1;
        end
      end
      // Completion wins over a same-cycle flush; otherwise the access drains.
      GNT_I:            if (mem_ack_i) state_d = IDLE;
                        else if (flush_i) state_d = GNT_I_KILL;
      GNT_D, GNT_I_KILL: if (mem_ack_i) state_d = IDLE;
      default:          state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      starve_q <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      we_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      we_q     <= we_d;
    end
  end

  assign mem_req_o   = (state_q != IDLE);
  assign mem_we_o    = mem_req_o & we_q;
  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = wdata_q;
  assign if_ack_o    = (state_q == GNT_I) & mem_ack_i;
  assign d_ack_o     = (state_q == GNT_D) & mem_ack_i;
  assign if_rdata_o  = if_ack_o ? mem_rdata_i : '0;
  assign d_rdata_o   = d_ack_o  ? mem_rdata_i : '0;
  assign stall_o     = (if_req_i & ~if_ack_o & ~flush_i) | (d_req_i & ~d_ack_o);

  sat_counter #(.W(LAT_W)) u_if_wait (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .inc_i (if_req_i & ~if_ack_o),
    .clr_i (1'b0),
    .cnt_o (if_wait_cnt_o)
  );

  sat_counter #(.W(LAT_W)) u_d_wait (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .inc_i (d_req_i & ~d_ack_o),
    .clr_i (1'b0),
    .cnt_o (d_wait_cnt_o)
  );
endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus a randomized
// run against a transaction-level reference model.
module tb_mem_arbiter;
  localparam int LIMIT = 4;

  logic        clk, rst;
  logic        if_req, flush, d_req, d_we, mem_ack;
  logic [31:0] if_addr, d_addr, d_wdata, mem_rdata;
  logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata, if_wc, d_wc;
  logic        if_ack, d_ack, mem_req, mem_we, stall;

  logic        s_if_req;
  logic [31:0] s_if_rdata, s_d_rdata, s_mem_addr, s_mem_wdata;
  logic        s_if_ack, s_d_ack, s_mem_req, s_mem_we, s_stall;
  logic [3:0]  s_if_wc, s_d_wc;

  int nvec = 0;
  int nerr = 0;

  mem_arbiter dut (
    .clk_i(clk), .rst_i(rst),
    .if_req_i(if_req), .if_addr_i(if_addr), .if_rdata_o(if_rdata), .if_ack_o(if_ack),
    .flush_i(flush),
    .d_req_i(d_req), .d_we_i(d_we), .d_addr_i(d_addr), .d_wdata_i(d_wdata),
    .d_rdata_o(d_rdata), .d_ack_o(d_ack),
    .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
    .mem_rdata_i(mem_rdata), .mem_ack_i(mem_ack),
    .stall_o(stall), .if_wait_cnt_o(if_wc), .d_wait_cnt_o(d_wc)
  );

  mem_arbiter #(.LAT_W(4)) u_sat (
    .clk_i(clk), .rst_i(rst),
    .if_req_i(s_if_req), .if_addr_i(32'h10), .if_rdata_o(s_if_rdata), .if_ack_o(s_if_ack),
    .flush_i(1'b0),
    .d_req_i(1'b0), .d_we_i(1'b0), .d_addr_i(32'd0), .d_wdata_i(32'd0),
    .d_rdata_o(s_d_rdata), .d_ack_o(s_d_ack),
    .mem_req_o(s_mem_req), .mem_we_o(s_mem_we), .mem_addr_o(s_mem_addr), .mem_wdata_o(s_mem_wdata),
    .mem_rdata_i(32'd0), .mem_ack_i(1'b0),
    .stall_o(s_stall), .if_wait_cnt_o(s_if_wc), .d_wait_cnt_o(s_d_wc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk); #2;
  endtask

  task automatic do_reset();
    rst = 1'b1; if_req = 0; flush = 0; d_req = 0; d_we = 0; mem_ack = 0; s_if_req = 0;
    if_addr = 0; d_addr = 0; d_wdata = 0; mem_rdata = 0;
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; if_req = 1; d_req = 1; d_we = 1; mem_ack = 1; mem_rdata = 32'hdeadbeef;
    if_addr = 32'h44; d_addr = 32'h88; d_wdata = 32'h1234; flush = 0; s_if_req = 0;
    repeat (2) @(posedge clk); #2;
    nvec++; if ({mem_req, mem_we, if_ack, d_ack} !== 4'b0) begin nerr++; $display("FAIL reset_ctl: got %b want 0000", {mem_req, mem_we, if_ack, d_ack}); end
    nvec++; if (mem_addr !== 0 || mem_wdata !== 0) begin nerr++; $display("FAIL reset_mem_bus: got %h/%h want 0/0", mem_addr, mem_wdata); end
    nvec++; if (if_rdata !== 0 || d_rdata !== 0) begin nerr++; $display("FAIL reset_rdata: got %h/%h want 0/0", if_rdata, d_rdata); end
    nvec++; if (if_wc !== 0 || d_wc !== 0) begin nerr++; $display("FAIL reset_cnt: got %0d/%0d want 0/0", if_wc, d_wc); end
  endtask

  task automatic test_fetch();
    logic [31:0] rv;
    do_reset();
    if_req = 1; if_addr = 32'h04; #1;
    nvec++; if (mem_req !== 0 || stall !== 1) begin nerr++; $display("FAIL fetch_idle: got req=%b stall=%b want 0/1", mem_req, stall); end
    step();
    nvec++; if (mem_req !== 1 || mem_addr !== 32'h04 || mem_we !== 0) begin nerr++; $display("FAIL fetch_grant: got req=%b addr=%h we=%b want 1/04/0", mem_req, mem_addr, mem_we); end
    step();
    rv = $urandom; mem_rdata = rv; mem_ack = 1; #1;
    nvec++; if (if_ack !== 1 || d_ack !== 0 || if_rdata !== rv) begin nerr++; $display("FAIL fetch_ack: got ack=%b/%b rdata=%h want 1/0/%h", if_ack, d_ack, if_rdata, rv); end
    step();
    mem_ack = 0; if_req = 0; #1;
    nvec++; if (if_wc !== 2 || mem_req !== 0) begin nerr++; $display("FAIL fetch_wait_cnt: got %0d req=%b want 2/0", if_wc, mem_req); end
  endtask

  task automatic test_starve_order();
    int  wt;
    logic exp_d;
    do_reset();
    if_req = 1; if_addr = 32'h100; d_req = 1; d_addr = 32'h200; d_we = 0;
    for (int g = 0; g < 10; g++) begin
      wt = 0;
      while (!mem_req && wt < 10) begin step(); wt++; end
      exp_d = ((g % 5) != 4);
      nvec++;
      if (!mem_req) begin nerr++; $display("FAIL starve_timeout: grant %0d never came", g); end
      else if (mem_addr !== (exp_d ? 32'h200 : 32'h100)) begin
        nerr++; $display("FAIL starve_order: grant %0d got addr %h want %h", g, mem_addr, exp_d ? 32'h200 : 32'h100);
      end
      mem_ack = 1; #1;
      nvec++; if ({if_ack, d_ack} !== (exp_d ? 2'b01 : 2'b10)) begin nerr++; $display("FAIL starve_ack: grant %0d got %b want %b", g, {if_ack, d_ack}, exp_d ? 2'b01 : 2'b10); end
      step();
      mem_ack = 0;
    end
    if_req = 0; d_req = 0;
  endtask

  task automatic test_store();
    int acks = 0;
    do_reset();
    d_req = 1; d_we = 1; d_addr = 32'h08; d_wdata = 32'd5;
    step();
    for (int c = 0; c < 3; c++) begin
      mem_ack = (c == 2); #1;
      nvec++; if (mem_req !== 1 || mem_we !== 1 || mem_addr !== 32'h08 || mem_wdata !== 32'd5) begin
        nerr++; $display("FAIL store_hold: cyc %0d got req=%b we=%b addr=%h wd=%h want 1/1/08/5", c, mem_req, mem_we, mem_addr, mem_wdata);
      end
      if (d_ack) acks++;
      step();
      mem_ack = 0;
      if (c == 2) d_req = 0;
    end
    for (int c = 0; c < 3; c++) begin #1; if (d_ack) acks++; step(); end
    nvec++; if (acks !== 1) begin nerr++; $display("FAIL store_ack_count: got %0d want 1", acks); end
  endtask

  task automatic test_flush();
    int ifacks = 0;
    do_reset();
    if_req = 1; if_addr = 32'h40;
    step();
    flush = 1; #1;
    nvec++; if (mem_req !== 1 || stall !== 0) begin nerr++; $display("FAIL flush_cycle: got req=%b stall=%b want 1/0", mem_req, stall); end
    step();
    flush = 0; if_req = 0; if_addr = 32'h99;
    for (int c = 0; c < 3; c++) begin
      mem_ack = (c == 2); #1;
      nvec++; if (mem_req !== 1 || mem_addr !== 32'h40) begin nerr++; $display("FAIL flush_drain: cyc %0d got req=%b addr=%h want 1/40", c, mem_req, mem_addr); end
      if (if_ack || d_ack) ifacks++;
      step();
      mem_ack = 0;
    end
    #1;
    nvec++; if (mem_req !== 0 || ifacks !== 0) begin nerr++; $display("FAIL flush_end: got req=%b acks=%0d want 0/0", mem_req, ifacks); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    d_req = 1; d_addr = 32'h30; if_req = 1; if_addr = 32'h50;
    step(); step();
    nvec++; if (mem_req !== 1 || mem_addr !== 32'h30) begin nerr++; $display("FAIL rstmid_grant: got req=%b addr=%h want 1/30", mem_req, mem_addr); end
    #1 rst = 1; #1;
    nvec++; if (mem_req !== 0 || mem_addr !== 0 || if_wc !== 0 || d_wc !== 0) begin
      nerr++; $display("FAIL rstmid_async: got req=%b addr=%h cnt=%0d/%0d want 0/0/0/0", mem_req, mem_addr, if_wc, d_wc);
    end
    d_req = 0; if_req = 0;
    step(); rst = 0;
    step(); mem_ack = 1; #1;
    nvec++; if (if_ack !== 0 || d_ack !== 0 || mem_req !== 0) begin nerr++; $display("FAIL rstmid_stale_ack: got %b%b req=%b want 00/0", if_ack, d_ack, mem_req); end
    step(); mem_ack = 0;
  endtask

  task automatic test_saturate();
    do_reset();
    s_if_req = 1;
    repeat (14) step();
    nvec++; if (s_if_wc !== 4'd14) begin nerr++; $display("FAIL sat_count: got %0d want 14", s_if_wc); end
    repeat (5) step();
    nvec++; if (s_if_wc !== 4'd15) begin nerr++; $display("FAIL sat_hold: got %0d want 15", s_if_wc); end
    s_if_req = 0;
  endtask

  // Reference model: owner 0=none, 1=fetch, 2=data, 3=cancelled fetch.
  task automatic test_random();
    int          owner = 0, starve = 0;
    longint      ifw = 0, dw = 0;
    logic [31:0] l_addr = 0, l_wd = 0;
    logic        l_we = 0, p_if_ack = 0, p_d_ack = 0, p_flush = 0;
    logic        e_if_ack, e_d_ack, e_stall;
    do_reset();
    for (int n = 0; n < 400; n++) begin
      if (if_req && (p_if_ack || p_flush)) if_req = 0;
      else if (!if_req && $urandom_range(1) == 1) begin if_req = 1; if_addr = $urandom & 32'hfffffffc; end
      if (d_req && p_d_ack) d_req = 0;
      else if (!d_req && $urandom_range(1) == 1) begin
        d_req = 1; d_we = ($urandom_range(1) == 1); d_addr = $urandom; d_wdata = $urandom;
      end
      flush = ($urandom_range(7) == 0);
      mem_ack = ($urandom_range(2) == 0);
      mem_rdata = $urandom;
      #1;
      e_if_ack = (owner == 1) && mem_ack;
      e_d_ack  = (owner == 2) && mem_ack;
      e_stall  = (if_req && !e_if_ack && !flush) || (d_req && !e_d_ack);
      nvec++; if (mem_req !== (owner != 0)) begin nerr++; $display("FAIL rnd_req: cyc %0d got %b want %b", n, mem_req, owner != 0); end
      nvec++; if ({if_ack, d_ack} !== {e_if_ack, e_d_ack}) begin nerr++; $display("FAIL rnd_ack: cyc %0d got %b%b want %b%b", n, if_ack, d_ack, e_if_ack, e_d_ack); end
      nvec++; if (if_rdata !== (e_if_ack ? mem_rdata : 32'd0) || d_rdata !== (e_d_ack ? mem_rdata : 32'd0)) begin
        nerr++; $display("FAIL rnd_rdata: cyc %0d got %h/%h", n, if_rdata, d_rdata);
      end
      nvec++; if (mem_we !== (owner == 2 && l_we)) begin nerr++; $display("FAIL rnd_we: cyc %0d got %b want %b", n, mem_we, owner == 2 && l_we); end
      if (owner != 0) begin
        nvec++; if (mem_addr !== l_addr) begin nerr++; $display("FAIL rnd_addr: cyc %0d got %h want %h", n, mem_addr, l_addr); end
      end
      if (owner == 2) begin
        nvec++; if (mem_wdata !== l_wd) begin nerr++; $display("FAIL rnd_wdata: cyc %0d got %h want %h", n, mem_wdata, l_wd); end
      end
      nvec++; if (stall !== e_stall) begin nerr++; $display("FAIL rnd_stall: cyc %0d got %b want %b", n, stall, e_stall); end
      nvec++; if (64'(if_wc) != ifw || 64'(d_wc) != dw) begin nerr++; $display("FAIL rnd_wait_cnt: cyc %0d got %0d/%0d want %0d/%0d", n, if_wc, d_wc, ifw, dw); end

      if (if_req && !e_if_ack && ifw < 64'hffffffff) ifw++;
      if (d_req && !e_d_ack && dw < 64'hffffffff) dw++;
      case (owner)
        0: if (if_req && !flush && (!d_req || starve >= LIMIT)) begin
             owner = 1; starve = 0; l_addr = if_addr; l_we = 0;
           end else if (d_req) begin
             owner = 2; l_addr = d_addr; l_wd = d_wdata; l_we = d_we;
             if (if_req && starve < 7) starve++;
           end
        1: if (mem_ack) owner = 0; else if (flush) owner = 3;
        default: if (mem_ack) owner = 0;
      endcase
      p_if_ack = e_if_ack; p_d_ack = e_d_ack; p_flush = flush;
      step();
    end
    if_req = 0; d_req = 0; flush = 0; mem_ack = 0;
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_starve_order();
    test_store();
    test_flush();
    test_reset_mid();
    test_saturate();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter STARVE_LIMIT, default 4, is the number of consecutive instruction-port losses after which the instruction port wins.
REQ-002 Parameter LAT_W, default 32, is the width of the wait-cycle counters.
REQ-003 clk_i  in  1  single clock; all state updates on the rising edge.
REQ-004 rst_i  in  1  asynchronous, active-high reset.
REQ-005 if_req_i  in  1  fetch request, held until if_ack_o.
REQ-006 if_addr_i  in  32  fetch byte address.
REQ-007 if_rdata_o  out  32  fetch data, valid while if_ack_o is high.
REQ-008 if_ack_o  out  1  one-cycle fetch completion.
REQ-009 flush_i  in  1  pipeline flush (taken branch or jump); cancels the pending fetch.
REQ-010 d_req_i / d_we_i  in  1 / 1  data request, held until d_ack_o, plus write enable.
REQ-011 d_addr_i / d_wdata_i  in  32 / 32  data address and write data.
REQ-012 d_rdata_o / d_ack_o  out  32 / 1  load data and one-cycle data completion.
REQ-013 mem_req_o / mem_we_o  out  1 / 1  memory request and write enable.
REQ-014 mem_addr_o / mem_wdata_o  out  32 / 32  memory address and write data.
REQ-015 mem_rdata_i / mem_ack_i  in  32 / 1  memory read data and completion; latency is one or more cycles and variable.
REQ-016 stall_o  out  1  high while any requester is waiting, for the hazard unit.
REQ-017 if_wait_cnt_o / d_wait_cnt_o  out  LAT_W / LAT_W  per-port wait-cycle counters.

Function
REQ-018 FSM states: IDLE, GNT_I, GNT_D, GNT_I_KILL.
REQ-019 IDLE, d_req_i=1, starve<STARVE_LIMIT: next state GNT_D.
REQ-020 IDLE, if_req_i=1, and (d_req_i=0 or starve>=STARVE_LIMIT): next state GNT_I.
REQ-021 IDLE, if_req_i=1 and flush_i=1 in the same cycle: no fetch grant; data arbitration is unaffected.
REQ-022 In GNT_x, mem_req_o=1 and the memory outputs carry the granted port's address, data and we (mem_we_o=0 for fetch), stable until mem_ack_i.
REQ-023 GNT_x with mem_ack_i=1: the granted port's ack is 1 in that same cycle; rdata is passed through combinationally from mem_rdata_i; next state IDLE.
REQ-024 Minimum access is 2 cycles: one grant cycle plus one IDLE cycle, so there are no back-to-back grants.
REQ-025 flush_i=1 in GNT_I: next state GNT_I_KILL; the memory transaction runs to mem_ack_i with unchanged outputs.
REQ-026 In GNT_I_KILL, if_ack_o stays 0; on mem_ack_i the next state is IDLE.
REQ-027 The starve counter (3 bits, saturating) increments when IDLE grants data while if_req_i=1; it clears on any GNT_I entry.
REQ-028 stall_o = (if_req_i & ~if_ack_o & ~flush_i) | (d_req_i & ~d_ack_o), combinational.
REQ-029 if_wait_cnt_o increments on each cycle with if_req_i=1 and if_ack_o=0; d_wait_cnt_o likewise for the data port.
REQ-030 Both counters saturate at all-ones and never wrap.
REQ-031 The un-granted port's ack is 0 in every state; both acks are never high together.
REQ-032 The design holds no request queue; requester inputs are sampled only in IDLE.

Reset
REQ-033 rst_i=1 immediately forces state IDLE, starve=0, both wait counters 0, mem_req_o=0, mem_we_o=0 and both acks 0.
REQ-034 Under reset, mem_addr_o, mem_wdata_o and the rdata outputs read 0.
REQ-035 Reset during GNT_x abandons the access: no ack is produced, and a late mem_ack_i after reset release while in IDLE is ignored.
REQ-036 The first grant is possible on the first rising edge after rst_i falls.

Structure
REQ-037 The FSM state encoding and the default STARVE_LIMIT belong in the shared CPU package.
REQ-038 One sub-module, sat_counter (parameterised width, inc, clr), is instantiated for each wait counter.

Verification
REQ-039 if_req_i=1 at addr 0x04, mem_ack_i 1 cycle after grant: mem_addr_o=0x04 and if_ack_o=1 with if_rdata_o equal to mem_rdata_i; if_wait_cnt_o=2.
REQ-040 if_req_i and d_req_i asserted together, both held: grant order D,D,D,D,I; the starve counter returns to 0 after the I grant.
REQ-041 Data store d_we_i=1 at addr 0x08, wdata 5, with 3-cycle memory latency: mem_we_o=1 with mem_addr_o=0x08 and mem_wdata_o=5 held 3 cycles; d_ack_o=1 once.
REQ-042 Fetch granted, flush_i pulsed mid-access: mem_req_o held until mem_ack_i, if_ack_o never rises, and the state returns to IDLE.
REQ-043 rst_i raised during GNT_D: mem_req_o=0 without waiting for a clock edge, counters=0, and a stale mem_ack_i after reset release produces no ack.
REQ-044 if_req_i held 2^LAT_W+3 cycles with LAT_W=4 and memory never acking: if_wait_cnt_o saturates at 15.
